// File: rtl/bus_arbiter_2to1.sv
// ---------------------------------------------------------------------------
// bus_arbiter_2to1
// Two masters share one req/ack/resp slave port. One eligible master is
// granted per cycle (round-robin or fixed m0 priority) and its request is
// forwarded combinationally. The ID of every accepted read is queued in an
// in-order routing FIFO, and each slave read response goes to the master
// at the FIFO head.
//
// Parameters:
//   ARB_MODE  "RR" round-robin, "FIXED" m0 always wins ties
//   RD_DEPTH  maximum outstanding reads (1..16)
// Ports:
//   clk_i, rst_i               clock, synchronous active-low reset
//   mN_req_i/we_i/addr_bi/be_bi/wdata_bi   master N request
//   mN_ack_o                   master N request accepted this cycle
//   mN_resp_o, mN_rdata_bo     master N read response
//   s_req_o/we_o/addr_bo/be_bo/wdata_bo    slave request (granted master)
//   s_ack_i, s_resp_i, s_rdata_bi          slave handshake / response
//   err_o                      sticky: response arrived with nothing queued
// ---------------------------------------------------------------------------
module bus_arbiter_2to1 #(
    parameter string ARB_MODE = "RR",
    parameter int    RD_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_addr_bi,
    input  logic [3:0]  m0_be_bi,
    input  logic [31:0] m0_wdata_bi,
    output logic        m0_ack_o,
    output logic        m0_resp_o,
    output logic [31:0] m0_rdata_bo,
    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_addr_bi,
    input  logic [3:0]  m1_be_bi,
    input  logic [31:0] m1_wdata_bi,
    output logic        m1_ack_o,
    output logic        m1_resp_o,
    output logic [31:0] m1_rdata_bo,
    output logic        s_req_o,
    output logic        s_we_o,
    output logic [31:0] s_addr_bo,
    output logic [3:0]  s_be_bo,
    output logic [31:0] s_wdata_bo,
    input  logic        s_ack_i,
    input  logic        s_resp_i,
    input  logic [31:0] s_rdata_bi,
    output logic        err_o
);

    localparam int CW = $clog2(RD_DEPTH + 1);
    localparam int PW = (RD_DEPTH > 1) ? $clog2(RD_DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(RD_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(RD_DEPTH - 1);
    localparam bit FIXED_PRI = (ARB_MODE == "FIXED");

    logic [CW-1:0] count;
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          id_mem [RD_DEPTH];
    logic          last_grant;
    logic          err_q;

    logic room, elig0, elig1, gnt0, gnt1;
    logic accept, push, pop, head;

    // Fullness is judged on the count at the start of the cycle, so a pop
    // in the same cycle never unblocks a stalled read.
    assign room  = (count < DEPTH_C);
    assign elig0 = m0_req_i & (m0_we_i | room);
    assign elig1 = m1_req_i & (m1_we_i | room);

    // m0 wins when alone, under fixed priority, or when m1 had the last grant.
    assign gnt0 = elig0 & (~elig1 | FIXED_PRI | last_grant);
    assign gnt1 = elig1 & ~gnt0;

    always_comb begin
        s_req_o    = gnt0 | gnt1;
        s_we_o     = m0_we_i;
        s_addr_bo  = m0_addr_bi;
        s_be_bo    = m0_be_bi;
        s_wdata_bo = m0_wdata_bi;
        if (gnt1) begin
            s_we_o     = m1_we_i;
            s_addr_bo  = m1_addr_bi;
            s_be_bo    = m1_be_bi;
            s_wdata_bo = m1_wdata_bi;
        end
    end

    assign m0_ack_o = gnt0 & s_ack_i;
    assign m1_ack_o = gnt1 & s_ack_i;

    assign accept = s_req_o & s_ack_i;
    assign push   = accept & ~s_we_o;
    assign pop    = s_resp_i & (count != '0);
    assign head   = id_mem[rd_ptr];

    assign m0_resp_o   = pop & ~head;
    assign m1_resp_o   = pop & head;
    assign m0_rdata_bo = s_rdata_bi;
    assign m1_rdata_bo = s_rdata_bi;
    assign err_o       = err_q;

    // ID storage carries no reset; only entries between the pointers matter.
    always_ff @(posedge clk_i) begin
        if (push)
            id_mem[wr_ptr] <= gnt1;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            count      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            last_grant <= 1'b1;
            err_q      <= 1'b0;
        end else begin
            if (accept)
                last_grant <= gnt1;
            if (push)
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (s_resp_i && count == '0)
                err_q <= 1'b1;
        end
    end

endmodule

// File: doc/bus_arbiter_2to1.md
# bus_arbiter_2to1

Two-master to one-slave arbiter for the req/ack/resp memory bus, placed directly upstream of one port of the dual-port RAM wrapper. Typical use: instruction-fetch and data masters sharing a single RAM port. Each cycle it selects one requesting master and forwards its request to the slave. It records the master ID of every accepted read in an in-order FIFO and uses that FIFO to route each slave read response back to the issuing master.

## Interface
- ARB_MODE, "RR": "RR" is round-robin; "FIXED" gives m0 absolute priority.
- RD_DEPTH, 4: maximum outstanding reads (routing FIFO depth), 1..16.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-low (rst_i==0 resets on clk_i edge).
- mN_req_i  in  1  master N request (N = 0, 1).
- mN_we_i  in  1  master N write enable.
- mN_addr_bi  in  32  master N byte address.
- mN_be_bi  in  4  master N byte enables.
- mN_wdata_bi  in  32  master N write data.
- mN_ack_o  out  1  master N request accepted this cycle.
- mN_resp_o  out  1  master N read data valid.
- mN_rdata_bo  out  32  master N read data.
- s_req_o, s_we_o, s_addr_bo[32], s_be_bo[4], s_wdata_bo[32]  out  slave request, muxed from the granted master.
- s_ack_i  in  1  slave accepted request.
- s_resp_i  in  1  slave read response valid.
- s_rdata_bi  in  32  slave read data.
- err_o  out  1  sticky flag: a response arrived with no outstanding read.

## Operation
- Eligibility:
  - A master is eligible if mN_req_i==1 and either it is a write (mN_we_i==1) or FIFO count < RD_DEPTH.
  - Writes are never tracked and never blocked by the FIFO.
- Grant (combinational, at most one per cycle):
  - Only one master eligible: that master is granted.
  - Both eligible, FIXED: m0 is granted.
  - Both eligible, RR: the master not equal to last_grant is granted.
- Slave request:
  - s_req_o = 1 when any grant is made; otherwise 0.
  - s_we/addr/be/wdata are driven from the granted master. When no grant is made they are driven from m0 (don't-care).
- Acknowledge:
  - mN_ack_o = grantN & s_ack_i.
  - The ungranted master's ack is 0 and it must hold its request.
- last_grant register: updated to the granted ID only when s_req_o & s_ack_i. Reset value is 1, so m0 wins the first RR tie.
- Routing FIFO:
  - Push the granted ID when s_req_o & s_ack_i & ~s_we_o.
  - Pop when s_resp_i & count!=0.
  - Push and pop in the same cycle leave the count unchanged; this is legal even when full.
  - Pointers wrap modulo RD_DEPTH; count is 0..RD_DEPTH.
- Response routing (combinational, zero added latency):
  - mN_resp_o = s_resp_i & (count!=0) & (head==N).
  - Both mN_rdata_bo = s_rdata_bi.
- Spurious response: s_resp_i with count==0 drives no mN_resp_o and sets err_o on the next edge. err_o is cleared only by reset.
- Responses return strictly in request order. The slave must not reorder them.

## Timing
- Reset values:
  - FIFO is empty (count 0, pointers 0), last_grant = 1, err_o = 0.
  - Hence m0_resp_o = m1_resp_o = 0.
  - s_req_o follows the inputs combinationally.
- Request path is combinational, so a request is forwarded in the same cycle it is presented.
- With the RAM wrapper (ack = req, resp one cycle later): a read accepted at cycle N gives mN_resp_o at cycle N+1.
- Sustained throughput: one accepted transaction per cycle.
- Full-FIFO read requests are stalled. They are accepted in the first cycle count < RD_DEPTH as seen at the start of that cycle; a same-cycle pop does not unblock them.
- Reset mid-operation:
  - Outstanding read IDs are discarded.
  - Slave responses arriving after reset for pre-reset reads count as spurious and set err_o.

## Test plan
- m0 read 0x10 in FIXED or RR mode, RAM returns 0xDEADBEEF -> m0_ack_o=1 at cycle N; m0_resp_o=1 with rdata 0xDEADBEEF at N+1; m1_resp_o stays 0.
- RR mode, both masters issuing back-to-back reads for 6 cycles -> grants alternate m0,m1,m0,m1,m0,m1; each response lands at the issuing master in order, with RAM data matching the address.
- FIXED mode, both requesting continuously for 5 cycles -> m0_ack_o=1 every cycle and m1_ack_o=0; m1 is granted in the first cycle m0_req_i drops.
- Slave holding s_resp_i=0 with RD_DEPTH=4: m0 issues 4 reads (all acked), 5th m0 read -> m0_ack_o=0; a simultaneous m1 write is acked and forwarded; 4 responses then route to m0; the 5th read is accepted after the first pop.
- s_resp_i pulsed with no outstanding read -> no mN_resp_o; err_o=1 from the next cycle and held until rst_i=0.
- Assert rst_i=0 for one cycle with 2 reads outstanding -> FIFO is cleared; the following 2 slave responses produce no mN_resp_o and err_o=1.
